// File: rtl/fifo_wr_arbiter.sv
// +----------------------------------------------------------------------------+
// | fifo_wr_arbiter: round-robin write arbiter with burst lock for a FIFO port |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  input  logic                        fifo_full,
  output logic                        fifo_w_en,
  output logic [DATA_WIDTH-1:0]       fifo_data_in,
  output logic                        locked,
  output logic [$clog2(N_REQ)-1:0]    owner
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [CW-1:0] cnt;

  logic          grant_valid;
  logic [IW-1:0] sel;
  logic [IW-1:0] cand;

  // The lock owner keeps the port while it requests; otherwise search from last+1,
  // which leaves the previous owner at lowest priority.
  always_comb begin
    grant_valid = 1'b0;
    sel         = last;
    cand        = last;
    if (state == LOCKED && req[last]) begin
      grant_valid = 1'b1;
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand = IW'((int'(last) + k) % N_REQ);
        if (!grant_valid && req[cand]) begin
          grant_valid = 1'b1;
          sel         = cand;
        end
      end
    end
    if (rst || fifo_full) begin
      grant_valid = 1'b0;
    end
  end

  always_comb begin
    gnt          = '0;
    fifo_data_in = '0;
    if (grant_valid) begin
      gnt[sel] = 1'b1;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign fifo_w_en = |(req & gnt);
  assign locked    = (state == LOCKED);
  assign owner     = last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= IW'(N_REQ - 1);
      cnt   <= '0;
    end else if (grant_valid) begin
      last <= sel;
      if (state == LOCKED && sel == last) begin
        if (cnt == CW'(MAX_BURST - 1)) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (MAX_BURST > 1) begin
        // Fresh grant or handover from an owner that dropped its request.
        state <= LOCKED;
        cnt   <= CW'(1);
      end else begin
        state <= IDLE;
        cnt   <= '0;
      end
    end else if (state == LOCKED && !fifo_full && !req[last]) begin
      state <= IDLE;
      cnt   <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios and randomized producers
// compared against a behavioural arbitration model and a FIFO scoreboard.
`default_nettype none

module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           fifo_full;
  logic [N-1:0]   gnt0, gnt1;
  logic           wen0, wen1;
  logic [W-1:0]   dat0, dat1;
  logic           lk0, lk1;
  logic [1:0]     own0, own1;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(W), .MAX_BURST(4)) dut0 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt0),
    .fifo_full(fifo_full), .fifo_w_en(wen0), .fifo_data_in(dat0),
    .locked(lk0), .owner(own0)
  );

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(W), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt1),
    .fifo_full(fifo_full), .fifo_w_en(wen1), .fifo_data_in(dat1),
    .locked(lk1), .owner(own1)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: [0] tracks dut0 (burst 4), [1] tracks dut1 (burst 1).
  int burst[2] = '{4, 1};
  int m_last[2];
  int m_cnt[2];
  bit m_lock[2];
  int e_idx[2];

  function automatic int pick(int d);
    if (rst || fifo_full) return -1;
    if (m_lock[d] && req[m_last[d]]) return m_last[d];
    for (int k = 1; k <= N; k++) begin
      if (req[(m_last[d] + k) % N]) return (m_last[d] + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    return (i < 0) ? '0 : (N'(1) << i);
  endfunction

  function automatic logic [W-1:0] word_of(int i);
    return (i < 0) ? '0 : req_data[i*W +: W];
  endfunction

  task automatic predict();
    e_idx[0] = pick(0);
    e_idx[1] = pick(1);
  endtask

  task automatic model_update(int d);
    int g;
    g = e_idx[d];
    if (rst) begin
      m_lock[d] = 1'b0; m_cnt[d] = 0; m_last[d] = N - 1;
    end else if (g >= 0) begin
      if (m_lock[d] && g == m_last[d]) begin
        m_cnt[d]++;
        if (m_cnt[d] == burst[d]) begin m_lock[d] = 1'b0; m_cnt[d] = 0; end
      end else if (burst[d] > 1) begin
        m_lock[d] = 1'b1; m_cnt[d] = 1;
      end else begin
        m_lock[d] = 1'b0; m_cnt[d] = 0;
      end
      m_last[d] = g;
    end else if (m_lock[d] && !fifo_full && !req[m_last[d]]) begin
      m_lock[d] = 1'b0; m_cnt[d] = 0;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    predict();
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; fifo_full = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; fifo_full = 1'b0; req_data = {$urandom, $urandom} & '1;
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if ({gnt0, wen0, dat0, gnt1, wen1, dat1} !== '0) begin
        errors++;
        $display("FAIL reset_outputs c=%0d gnt0=%b wen0=%b dat0=%h gnt1=%b wen1=%b (want all 0)",
                 c, gnt0, wen0, dat0, gnt1, wen1);
      end
      tick();
    end
    rst = 1'b0; req = '0;
    settle();
    checks++;
    if (lk0 !== 1'b0 || own0 !== 2'd3 || lk1 !== 1'b0 || own1 !== 2'd3) begin
      errors++;
      $display("FAIL reset_state lk0=%b own0=%0d lk1=%b own1=%0d want 0/3/0/3", lk0, own0, lk1, own1);
    end
    checks++;
    if (wen0 !== 1'b0 || gnt0 !== '0) begin
      errors++;
      $display("FAIL reset_idle wen0=%b gnt0=%b want 0/0000", wen0, gnt0);
    end
    tick();
  endtask

  task automatic test_priority();
    int g;
    do_reset();
    req = '1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
    for (int c = 0; c < 17; c++) begin
      settle();
      g = (c / 4) % 4;
      checks++;
      if (gnt0 !== onehot(g) || wen0 !== 1'b1 || dat0 !== word_of(g)) begin
        errors++;
        $display("FAIL priority c=%0d gnt=%b want %b wen=%b dat=%h want %h",
                 c, gnt0, onehot(g), wen0, dat0, word_of(g));
      end
      checks++;
      if (lk0 !== m_lock[0] || own0 !== 2'(m_last[0])) begin
        errors++;
        $display("FAIL priority_state c=%0d locked=%b want %b owner=%0d want %0d",
                 c, lk0, m_lock[0], own0, m_last[0]);
      end
      tick();
      req_data[g*W +: W] = W'($urandom);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    do_reset();
    req = 4'b1010;
    for (int c = 0; c < 6; c++) begin
      settle();
      exp = (c % 2 == 0) ? 4'b0010 : 4'b1000;
      checks++;
      if (gnt1 !== exp || wen1 !== 1'b1 || lk1 !== 1'b0 || dat1 !== word_of(c % 2 == 0 ? 1 : 3)) begin
        errors++;
        $display("FAIL round_robin c=%0d gnt=%b want %b wen=%b locked=%b", c, gnt1, exp, wen1, lk1);
      end
      tick();
    end
  endtask

  task automatic test_full_stall();
    logic [N-1:0] exp_g[8] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000,
                               4'b0100, 4'b0100, 4'b1000};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req       = (c < 2) ? 4'b0100 : 4'b1100;
      fifo_full = (c >= 2 && c <= 4);
      settle();
      checks++;
      if (gnt0 !== exp_g[c] || wen0 !== |exp_g[c]) begin
        errors++;
        $display("FAIL full_stall c=%0d gnt=%b want %b wen=%b", c, gnt0, exp_g[c], wen0);
      end
      if (fifo_full) begin
        checks++;
        if (own0 !== 2'd2 || lk0 !== 1'b1) begin
          errors++;
          $display("FAIL full_hold c=%0d owner=%0d want 2 locked=%b want 1", c, own0, lk0);
        end
      end
      tick();
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b0001;
    settle();
    checks++;
    if (gnt0 !== 4'b0001) begin
      errors++; $display("FAIL release_first gnt=%b want 0001", gnt0);
    end
    tick();
    req = 4'b1000;
    settle();
    checks++;
    if (gnt0 !== 4'b1000 || wen0 !== 1'b1 || dat0 !== word_of(3)) begin
      errors++; $display("FAIL release_handover gnt=%b want 1000 wen=%b dat=%h", gnt0, wen0, dat0);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if (own0 !== 2'd3 || lk0 !== 1'b1 || gnt0 !== 4'b1000) begin
        errors++;
        $display("FAIL release_owner c=%0d owner=%0d want 3 locked=%b want 1 gnt=%b", c, own0, lk0, gnt0);
      end
      tick();
    end
    settle();
    checks++;
    if (lk0 !== 1'b0) begin
      errors++; $display("FAIL release_burst_end locked=%b want 0", lk0);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b0010;
    repeat (3) tick();
    settle();
    checks++;
    if (lk0 !== 1'b1 || own0 !== 2'd1) begin
      errors++; $display("FAIL midburst_lock locked=%b owner=%0d want 1/1", lk0, own0);
    end
    rst = 1'b1; req = '1;
    settle();
    checks++;
    if (gnt0 !== '0 || wen0 !== 1'b0 || dat0 !== '0) begin
      errors++; $display("FAIL midburst_rst gnt=%b wen=%b dat=%h want 0", gnt0, wen0, dat0);
    end
    tick();
    rst = 1'b0;
    settle();
    checks++;
    if (gnt0 !== 4'b0001) begin
      errors++; $display("FAIL midburst_after gnt=%b want 0001", gnt0);
    end
    tick();
  endtask

  task automatic test_data_integrity();
    logic [W-1:0] words[2][30];
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got, want, ew, d;
    int  ptr[2];
    bit  hold[2];
    int  prod_id[2] = '{0, 2};
    int  nread, g;
    bit  rd, w;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      ptr[p] = 0; hold[p] = 1'b0;
      for (int k = 0; k < 30; k++) words[p][k] = W'($urandom);
    end
    nread = 0;
    for (int cyc = 0; cyc < 4000 && nread < 60; cyc++) begin
      req = '0;
      for (int p = 0; p < 2; p++) begin
        if (ptr[p] < 30) begin
          if (!hold[p] && $urandom_range(0, 2) != 0) hold[p] = 1'b1;
          req_data[prod_id[p]*W +: W] = words[p][ptr[p]];
        end
        if (hold[p]) req[prod_id[p]] = 1'b1;
      end
      fifo_full = (fifo_q.size() >= DEPTH);
      rd = 1'($urandom_range(0, 1));
      settle();
      checks++;
      if (gnt0 !== onehot(e_idx[0]) || wen0 !== (e_idx[0] >= 0) || dat0 !== word_of(e_idx[0])) begin
        errors++;
        $display("FAIL integrity_grant cyc=%0d gnt=%b want %b wen=%b dat=%h want %h",
                 cyc, gnt0, onehot(e_idx[0]), wen0, dat0, word_of(e_idx[0]));
      end
      checks++;
      if (wen0 === 1'b1 && fifo_full) begin
        errors++; $display("FAIL integrity_full_write cyc=%0d wen=1 while full", cyc);
      end
      w  = wen0;
      d  = dat0;
      g  = e_idx[0];
      ew = word_of(g);
      tick();
      if (rd && fifo_q.size() > 0) begin
        got = fifo_q.pop_front();
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        nread++;
        checks++;
        if (got !== want) begin
          errors++; $display("FAIL integrity_word n=%0d got=%h want %h", nread, got, want);
        end
      end
      if (w === 1'b1) fifo_q.push_back(d);
      if (g >= 0) begin
        exp_q.push_back(ew);
        ptr[g == prod_id[0] ? 0 : 1]++;
        hold[g == prod_id[0] ? 0 : 1] = 1'b0;
      end
    end
    checks++;
    if (nread != 60 || exp_q.size() != 0 || fifo_q.size() != 0) begin
      errors++;
      $display("FAIL integrity_count read=%0d want 60 pending_exp=%0d pending_fifo=%0d",
               nread, exp_q.size(), fifo_q.size());
    end
    req = '0; fifo_full = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
    test_reset();
    test_priority();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    test_data_integrity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
